// File: rtl/vip_sobel_threshold_ctrl.sv
// Frame-synchronous threshold controller for the Sobel edge detector.
// Counts edge/valid pixels per frame and updates the threshold only between frames.
//
// state  | meaning
// SYNC   | after reset, counters held at 0 until the first frame boundary
// COUNT  | accumulating edge and valid pixels
// LATCH  | publish the frame counts, restart the counters, pulse frame_done
// UPDATE | load the new threshold, keep counting
module vip_sobel_threshold_ctrl #(
  parameter logic [7:0] THR_INIT = 8'd55,
  parameter logic [7:0] THR_MIN  = 8'd8,
  parameter logic [7:0] THR_MAX  = 8'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        post_frame_vsync,
  input  logic        post_frame_href,
  input  logic        post_frame_clken,
  input  logic        edge_flag,
  input  logic        cfg_auto,
  input  logic [7:0]  cfg_manual_thr,
  input  logic [3:0]  cfg_step,
  input  logic [19:0] cfg_target_lo,
  input  logic [19:0] cfg_target_hi,
  output logic [7:0]  sobel_threshold,
  output logic [19:0] frame_edge_cnt,
  output logic [19:0] frame_pix_cnt,
  output logic        frame_done,
  output logic [15:0] frame_num
);

  typedef enum logic [1:0] {SYNC, COUNT, LATCH, UPDATE} state_t;

  localparam logic [19:0] CNT_SAT = 20'hFFFFF;

  state_t      state_q;
  logic        vs_d_q;
  logic [19:0] edge_cnt_q, pix_cnt_q;
  logic [19:0] edge_cnt_d, pix_cnt_d;
  logic [19:0] frame_edge_q, frame_pix_q;
  logic        frame_done_q;
  logic [15:0] frame_num_q;
  logic [7:0]  thr_q, thr_d;
  logic [8:0]  thr_cand;
  logic        vs_rise, pix_qual, edge_qual;

  assign vs_rise   = post_frame_vsync & ~vs_d_q;
  assign pix_qual  = post_frame_clken & post_frame_href;
  assign edge_qual = pix_qual & edge_flag;

  assign pix_cnt_d  = (pix_cnt_q == CNT_SAT)  ? pix_cnt_q  : pix_cnt_q  + {19'd0, pix_qual};
  assign edge_cnt_d = (edge_cnt_q == CNT_SAT) ? edge_cnt_q : edge_cnt_q + {19'd0, edge_qual};

  // 9-bit candidate so thr+step cannot wrap; underflow is caught before subtracting.
  always_comb begin
    thr_cand = {1'b0, thr_q};
    if (frame_edge_q > cfg_target_hi)
      thr_cand = {1'b0, thr_q} + {5'd0, cfg_step};
    else if (frame_edge_q < cfg_target_lo)
      thr_cand = (thr_q < {4'd0, cfg_step}) ? 9'd0 : {1'b0, thr_q} - {5'd0, cfg_step};

    if (!cfg_auto)
      thr_d = cfg_manual_thr;
    else if (thr_cand > {1'b0, THR_MAX})
      thr_d = THR_MAX;
    else if (thr_cand < {1'b0, THR_MIN})
      thr_d = THR_MIN;
    else
      thr_d = thr_cand[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      vs_d_q       <= 1'b0;
      edge_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      frame_edge_q <= '0;
      frame_pix_q  <= '0;
      frame_done_q <= 1'b0;
      frame_num_q  <= '0;
      thr_q        <= THR_INIT;
    end else begin
      vs_d_q       <= post_frame_vsync;
      frame_done_q <= 1'b0;
      case (state_q)
        SYNC: begin
          edge_cnt_q <= '0;
          pix_cnt_q  <= '0;
          if (vs_rise) state_q <= COUNT;
        end
        COUNT: begin
          edge_cnt_q <= edge_cnt_d;
          pix_cnt_q  <= pix_cnt_d;
          if (vs_rise) state_q <= LATCH;
        end
        LATCH: begin
          frame_edge_q <= edge_cnt_q;
          frame_pix_q  <= pix_cnt_q;
          edge_cnt_q   <= {19'd0, edge_qual};
          pix_cnt_q    <= {19'd0, pix_qual};
          frame_done_q <= 1'b1;
          frame_num_q  <= frame_num_q + 16'd1;
          state_q      <= UPDATE;
        end
        UPDATE: begin
          edge_cnt_q <= edge_cnt_d;
          pix_cnt_q  <= pix_cnt_d;
          thr_q      <= thr_d;
          state_q    <= vs_rise ? LATCH : COUNT;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign sobel_threshold = thr_q;
  assign frame_edge_cnt  = frame_edge_q;
  assign frame_pix_cnt   = frame_pix_q;
  assign frame_done      = frame_done_q;
  assign frame_num       = frame_num_q;

endmodule

// File: tb/tb_vip_sobel_threshold_ctrl.sv
// Bench for vip_sobel_threshold_ctrl: directed and randomized frames checked
// against a frame-level reference model of counts, frame number and threshold.
module tb_vip_sobel_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        post_frame_vsync, post_frame_href, post_frame_clken, edge_flag;
  logic        cfg_auto;
  logic [7:0]  cfg_manual_thr;
  logic [3:0]  cfg_step;
  logic [19:0] cfg_target_lo, cfg_target_hi;
  logic [7:0]  sobel_threshold;
  logic [19:0] frame_edge_cnt, frame_pix_cnt;
  logic        frame_done;
  logic [15:0] frame_num;

  int checks = 0;
  int failures = 0;

  // reference model state
  int  m_thr = 55;
  int  m_num = 0;
  bit  m_active = 1'b0;
  int  pend_e = 0;
  int  pend_p = 0;

  vip_sobel_threshold_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .edge_flag        (edge_flag),
    .cfg_auto         (cfg_auto),
    .cfg_manual_thr   (cfg_manual_thr),
    .cfg_step         (cfg_step),
    .cfg_target_lo    (cfg_target_lo),
    .cfg_target_hi    (cfg_target_hi),
    .sobel_threshold  (sobel_threshold),
    .frame_edge_cnt   (frame_edge_cnt),
    .frame_pix_cnt    (frame_pix_cnt),
    .frame_done       (frame_done),
    .frame_num        (frame_num)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int model_thr(input int thr, input int edges);
    int t;
    if (!cfg_auto) return int'(cfg_manual_thr);
    t = thr;
    if (edges > int'(cfg_target_hi)) t = thr + int'(cfg_step);
    else if (edges < int'(cfg_target_lo)) t = thr - int'(cfg_step);
    if (t > 250) t = 250;
    if (t < 8) t = 8;
    return t;
  endfunction

  task automatic frame(input int h, input int w, input int n_edge);
    int  idx;
    bit  e;
    idx = 0;
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        while ($urandom_range(0, 3) == 0) begin
          post_frame_href = 1'b1; post_frame_clken = 1'b0; edge_flag = 1'($urandom_range(0, 1));
          tick();
        end
        e = (n_edge < 0) ? 1'($urandom_range(0, 1)) : (idx < n_edge);
        post_frame_href = 1'b1; post_frame_clken = 1'b1; edge_flag = e;
        tick();
        if (m_active) begin
          pend_p++;
          if (e) pend_e++;
        end
        idx++;
      end
      // blanking with clken/edge high but href low: nothing may be counted
      post_frame_href = 1'b0; post_frame_clken = 1'b1; edge_flag = 1'b1;
      tick();
      post_frame_clken = 1'b0; edge_flag = 1'b0;
    end
    check("thr_stable_in_frame", 32'(sobel_threshold), 32'(m_thr));
  endtask

  task automatic boundary(input bit latch_pix);
    int exp_e, exp_p, thr_old;
    bit was_active;
    was_active = m_active; exp_e = pend_e; exp_p = pend_p; thr_old = m_thr;
    post_frame_vsync = 1'b1; post_frame_href = 1'b0; post_frame_clken = 1'b0; edge_flag = 1'b0;
    tick();  // N
    check("thr_hold_n", 32'(sobel_threshold), 32'(thr_old));
    pend_e = 0; pend_p = 0;
    if (latch_pix) begin
      post_frame_href = 1'b1; post_frame_clken = 1'b1; edge_flag = 1'b1;
      pend_e = 1; pend_p = 1;
    end
    tick();  // N+1
    post_frame_href = 1'b0; post_frame_clken = 1'b0; edge_flag = 1'b0;
    if (was_active) begin
      m_num = (m_num + 1) & 16'hFFFF;
      check("done_n1", 32'(frame_done), 32'd1);
      check("edge_cnt", 32'(frame_edge_cnt), 32'(exp_e));
      check("pix_cnt", 32'(frame_pix_cnt), 32'(exp_p));
      check("frame_num", 32'(frame_num), 32'(m_num));
      m_thr = model_thr(m_thr, exp_e);
    end else begin
      check("done_sync_discard", 32'(frame_done), 32'd0);
      check("frame_num_sync", 32'(frame_num), 32'(m_num));
    end
    check("thr_hold_n1", 32'(sobel_threshold), 32'(thr_old));
    tick();  // N+2
    check("done_n2", 32'(frame_done), 32'd0);
    check("thr_n2", 32'(sobel_threshold), 32'(m_thr));
    m_active = 1'b1;
    post_frame_vsync = 1'b0;
    tick();
  endtask

  // vsync toggling every cycle pair: every rise must produce its own LATCH
  task automatic rapid(input int n);
    for (int k = 0; k < n; k++) begin
      post_frame_vsync = 1'b1;
      tick();
      if (k > 0) check("b2b_thr", 32'(sobel_threshold), 32'(m_thr));
      post_frame_vsync = 1'b0;
      tick();
      m_num = (m_num + 1) & 16'hFFFF;
      check("b2b_done", 32'(frame_done), 32'd1);
      check("b2b_pix", 32'(frame_pix_cnt), 32'(pend_p));
      check("b2b_edge", 32'(frame_edge_cnt), 32'(pend_e));
      check("b2b_num", 32'(frame_num), 32'(m_num));
      m_thr = model_thr(m_thr, pend_e);
      pend_e = 0; pend_p = 0;
    end
    tick();
    check("b2b_thr_last", 32'(sobel_threshold), 32'(m_thr));
    check("b2b_done_low", 32'(frame_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    post_frame_vsync = 1'b0; post_frame_href = 1'b0; post_frame_clken = 1'b0; edge_flag = 1'b0;
    cfg_auto = 1'b0; cfg_manual_thr = 8'd90; cfg_step = 4'd5;
    cfg_target_lo = 20'd10; cfg_target_hi = 20'd20;
    tick(); tick();
    check("rst_thr", 32'(sobel_threshold), 32'd55);
    check("rst_edge", 32'(frame_edge_cnt), 32'd0);
    check("rst_pix", 32'(frame_pix_cnt), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_num", 32'(frame_num), 32'd0);
    rst_n = 1'b1;
    tick();

    // manual mode, three 8x4 all-edge frames; the first is discarded
    frame(4, 8, 32);
    boundary(1'b0);
    frame(4, 8, 32);
    boundary(1'b0);
    frame(4, 8, 32);
    boundary(1'b0);
    check("num_after_3", 32'(frame_num), 32'd2);
    check("manual_thr_90", 32'(sobel_threshold), 32'd90);

    // mid-frame manual change only lands at N+2 of the next boundary
    frame(2, 8, -1);
    cfg_manual_thr = 8'd120;
    frame(2, 8, -1);
    boundary(1'b0);

    // pixel on the LATCH cycle belongs to the new frame
    frame(4, 8, 32);
    boundary(1'b1);
    frame(4, 8, 32);
    boundary(1'b0);
    check("latch_pix_new_frame", 32'(frame_pix_cnt), 32'd33);

    rapid(3);

    // manual value above THR_MAX is clamped by the first auto update
    cfg_manual_thr = 8'd252;
    frame(2, 4, -1);
    boundary(1'b0);
    cfg_auto = 1'b1; cfg_target_lo = 20'd0; cfg_target_hi = 20'd1000;
    frame(2, 4, -1);
    boundary(1'b0);
    check("clamp_from_manual", 32'(sobel_threshold), 32'd250);
    cfg_auto = 1'b0;

    // reset in the middle of a counted frame
    frame(2, 8, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_thr", 32'(sobel_threshold), 32'd55);
    check("midrst_edge", 32'(frame_edge_cnt), 32'd0);
    check("midrst_pix", 32'(frame_pix_cnt), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    check("midrst_num", 32'(frame_num), 32'd0);
    m_thr = 55; m_num = 0; m_active = 1'b0; pend_e = 0; pend_p = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // auto mode, band [10,20], step 5
    cfg_auto = 1'b1; cfg_step = 4'd5; cfg_target_lo = 20'd10; cfg_target_hi = 20'd20;
    frame(4, 8, 15);
    boundary(1'b0);
    for (int f = 0; f < 4; f++) begin
      frame(4, 8, 15);
      boundary(1'b0);
    end
    check("auto_in_band_55", 32'(sobel_threshold), 32'd55);
    for (int f = 0; f < 42; f++) begin
      frame(4, 8, 32);
      boundary(1'b0);
    end
    check("auto_top_250", 32'(sobel_threshold), 32'd250);
    for (int f = 0; f < 50; f++) begin
      frame(4, 8, 0);
      boundary(1'b0);
    end
    check("auto_bottom_8", 32'(sobel_threshold), 32'd8);

    // randomized configuration and traffic
    for (int f = 0; f < 30; f++) begin
      cfg_auto       = ($urandom_range(0, 3) != 0);
      cfg_manual_thr = 8'($urandom_range(0, 255));
      cfg_step       = 4'($urandom_range(0, 15));
      cfg_target_lo  = 20'($urandom_range(0, 16));
      cfg_target_hi  = cfg_target_lo + 20'($urandom_range(0, 12));
      frame($urandom_range(1, 5), $urandom_range(1, 8), -1);
      boundary(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vip_sobel_threshold_ctrl.md
# vip_sobel_threshold_ctrl

Frame-synchronous threshold controller for the Sobel edge detector in the OV7725 → HDMI video path. It counts edge and valid pixels per frame from the detector's output stream. At each frame boundary it either applies a manual threshold or adapts the threshold so the edge-pixel count stays inside a target band. The threshold it drives feeds the detector's compare stage and changes only between frames, never mid-frame.

## Interface
Parameters:
- THR_INIT, 8'd55: threshold after reset.
- THR_MIN, 8'd8: lower clamp for auto mode.
- THR_MAX, 8'd250: upper clamp for auto mode.

Ports:
- clk  in  1  pixel clock, the same clock as the detector.
- rst_n  in  1  asynchronous reset, active-low.
- post_frame_vsync  in  1  detector output vsync; a rising edge marks a frame boundary.
- post_frame_href  in  1  detector output href.
- post_frame_clken  in  1  detector output pixel-valid.
- edge_flag  in  1  detector output data bit 0 (1 = edge).
- cfg_auto  in  1  1 = adaptive threshold, 0 = manual threshold.
- cfg_manual_thr  in  8  threshold used in manual mode.
- cfg_step  in  4  auto-mode adjustment per frame; 0 freezes the threshold.
- cfg_target_lo  in  20  lower bound of the edge-count band.
- cfg_target_hi  in  20  upper bound of the edge-count band (≥ cfg_target_lo).
- sobel_threshold  out  8  threshold driven to the detector.
- frame_edge_cnt  out  20  edge pixels counted in the last complete frame.
- frame_pix_cnt  out  20  valid pixels counted in the last complete frame.
- frame_done  out  1  one-cycle pulse when both counts update.
- frame_num  out  16  number of complete frames since reset; wraps.

## Operation
- vsync edge detect: register post_frame_vsync into vs_d. vs_rise = vsync & ~vs_d.
- A pixel is counted when post_frame_clken & post_frame_href. The edge counter also requires edge_flag = 1.
- Both counters saturate at 20'hFFFFF.
- FSM states:
  - SYNC (after reset): counters held at 0. On vs_rise → COUNT. The first, partial frame is discarded.
  - COUNT: counters accumulate. On vs_rise → LATCH.
  - LATCH (1 cycle):
    - Copy the counters to frame_edge_cnt/frame_pix_cnt.
    - Clear the counters, but still count a qualifying pixel on this cycle: counter ← 0 + qualifying pixel.
    - Pulse frame_done and increment frame_num.
    - → UPDATE.
  - UPDATE (1 cycle):
    - Compute and load sobel_threshold. Counting continues.
    - On vs_rise in this cycle → LATCH. Otherwise → COUNT.
- Threshold rule, evaluated in UPDATE:
  - cfg_auto = 0: thr ← cfg_manual_thr. No clamp.
  - cfg_auto = 1, frame_edge_cnt > cfg_target_hi: thr ← min(thr + cfg_step, THR_MAX).
  - cfg_auto = 1, frame_edge_cnt < cfg_target_lo: thr ← max(thr − cfg_step, THR_MIN).
  - cfg_auto = 1, count inside the band (inclusive): thr unchanged.
  - Arithmetic is 9-bit to avoid wrap before clamping.
  - If the current thr is outside [THR_MIN, THR_MAX] (carried over from manual mode), the first auto update clamps it.
- Switching from manual to auto starts from the current sobel_threshold.
- cfg_* inputs are sampled only in UPDATE. Changes mid-frame take effect at the next boundary.
- Reset asserted mid-frame: all state returns to reset values immediately, and the FSM goes to SYNC.

## Timing
- Reset values:
  - sobel_threshold = THR_INIT.
  - frame_edge_cnt = 0, frame_pix_cnt = 0.
  - frame_done = 0, frame_num = 0.
  - FSM = SYNC.
- Cycle N = the clk edge where vsync is first sampled high with vs_d low.
- Counts and frame_done are valid at cycle N+1, which is LATCH.
- sobel_threshold is valid at cycle N+2 and stays stable until the next boundary.
- All outputs are registered. There is no combinational path from input to output.
- Back-to-back vs_rise, with vsync toggling every 2 cycles, is legal. Every boundary produces a LATCH.

## Test plan
- Reset, then three 8×4 frames, all edges, auto off, cfg_manual_thr = 90:
  - First frame discarded.
  - frame_pix_cnt = 32 and frame_edge_cnt = 32 after the 2nd and 3rd boundaries.
  - frame_num = 2.
  - sobel_threshold = 90, set exactly 2 cycles after each vs_rise.
- Auto mode, band [10, 20], step 5, 32 edges per frame: threshold follows 55 → 60 → 65…, ending at THR_MAX = 250 with no wrap. With 0 edges per frame it descends to THR_MIN = 8.
- Auto mode, 15 edges per frame: threshold stays at 55 for 4 frames.
- Change cfg_manual_thr mid-frame: sobel_threshold stays constant until N+2 of the next boundary.
- Pixel with clken = 1 on the LATCH cycle: it is counted in the new frame, not the old one. Expected counts differ by exactly 1.
- Assert rst_n low mid-COUNT: all outputs return to their reset values, and the next frame after release is discarded (SYNC).
